// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader.
//   - BRAM data width and byte-lane count
//   - BRAM registered read latency (address edge to data valid)
//   - FSM state encoding
//   - inflight_count(): number of reads currently in the latency pipeline
package bram_stream_reader_pkg;

    localparam int BRAM_DATA_W     = 32;
    localparam int BRAM_LANES      = 4;
    localparam int BRAM_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Popcount of the in-flight valid shift register (0..BRAM_RD_LATENCY).
    function automatic logic [1:0] inflight_count(input logic [BRAM_RD_LATENCY-1:0] v);
        logic [1:0] n;
        n = '0;
        for (int i = 0; i < BRAM_RD_LATENCY; i++) begin
            n = n + {1'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Bus bundle between the stream reader, its BRAM port and its downstream consumer.
//   Stream : m_data, m_valid (reader -> consumer), m_ready (consumer -> reader)
//   BRAM   : BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_WRDATA, BRAM_RST (reader -> BRAM),
//            BRAM_RDDATA (BRAM -> reader)
// master = reader side, slave = the BRAM / consumer side.
interface bram_stream_reader_if #(
    parameter int BRAM_ADDR_WIDTH = 15
);
    import bram_stream_reader_pkg::*;

    logic [BRAM_DATA_W-1:0]     m_data;
    logic                       m_valid;
    logic                       m_ready;
    logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR;
    logic                       BRAM_EN;
    logic [BRAM_LANES-1:0]      BRAM_WE;
    logic [BRAM_DATA_W-1:0]     BRAM_WRDATA;
    logic                       BRAM_RST;
    logic [BRAM_DATA_W-1:0]     BRAM_RDDATA;

    modport master (
        output m_data, m_valid, BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_WRDATA, BRAM_RST,
        input  m_ready, BRAM_RDDATA
    );

    modport slave (
        input  m_data, m_valid, BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_WRDATA, BRAM_RST,
        output m_ready, BRAM_RDDATA
    );

endinterface

// File: rtl/bram_stream_reader_sync_fifo.sv
// Small first-word-fall-through FIFO.
//   clk, rstn        : clock, asynchronous active-low reset (flushes the FIFO)
//   push, wr_data    : write request and data
//   pop              : remove head entry (ignored when empty)
//   rd_data          : head entry, valid whenever !empty
//   full, empty      : occupancy flags
//   count            : number of stored entries (0..DEPTH)
// Push on a full FIFO is accepted only if a pop happens in the same cycle.
module bram_stream_reader_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]            count_reg;
    logic [DEPTH-1:0][WIDTH-1:0] slots;
    logic                        do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_reg;
    assign rd_data = slots[rd_ptr_reg];

    // Storage carries no reset: contents are only visible through count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end
            assign slots[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side master for a 32-bit byte-addressed BRAM with a 2-cycle read.
// A start pulse fetches len consecutive words from base_addr (low two bits
// dropped) and streams them in order through a FWFT FIFO.
//   clk, rstn          : clock (also drives BRAM_CLK), async active-low reset
//   start, base_addr   : request pulse and byte base address (sampled in IDLE)
//   len                : number of words; 0 completes immediately
//   busy               : high in RUN and DONE
//   done               : one-cycle pulse after the last word is accepted
//   bus (master)       : stream (m_data/m_valid/m_ready) and BRAM port
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int LEN_WIDTH       = 13,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]       len,
    output logic                       busy,
    output logic                       done,
    bram_stream_reader_if.master       bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e                       state_reg, state_next;
    logic [BRAM_ADDR_WIDTH-1:0]   base_reg, addr_reg, issue_addr;
    logic [LEN_WIDTH-1:0]         len_reg, issued_reg, accepted_reg;
    logic [BRAM_RD_LATENCY-1:0]   vld_reg;
    logic [CNT_W-1:0]             fifo_count;
    logic [CNT_W:0]               credit_used;
    logic [BRAM_DATA_W-1:0]       fifo_rd_data;
    logic                         fifo_empty, unused_fifo_full;
    logic                         fifo_push, pop, issue, launch;

    assign launch      = (state_reg == ST_IDLE) && start && (len != '0);
    assign pop         = bus.m_valid && bus.m_ready;
    assign fifo_push   = vld_reg[BRAM_RD_LATENCY-1];
    assign issue_addr  = base_reg + BRAM_ADDR_WIDTH'({issued_reg, 2'b00});

    // Reads already in the pipeline reserve a FIFO slot, so the FIFO can
    // never be written while full no matter how long m_ready stays low.
    assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_count(vld_reg));
    assign issue       = (state_reg == ST_RUN) && (issued_reg < len_reg)
                         && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic; completion counts the handshake of the current cycle
    // so done follows the final transfer by exactly one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = (len != '0) ? ST_RUN : ST_DONE;
            ST_RUN:  if ((accepted_reg + LEN_WIDTH'(pop)) == len_reg) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs. EN stays up for all of RUN so the BRAM output register keeps
    // capturing while the last reads drain.
    always_comb begin
        busy        = (state_reg != ST_IDLE);
        done        = (state_reg == ST_DONE);
        bus.BRAM_EN = (state_reg == ST_RUN);
    end

    // Address shows the new word when issuing and otherwise holds the last one.
    assign bus.BRAM_ADDR   = issue ? issue_addr : addr_reg;
    assign bus.BRAM_WE     = '0;
    assign bus.BRAM_WRDATA = '0;
    assign bus.BRAM_RST    = 1'b0;

    // Transfer counters and read-latency tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_reg     <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            issued_reg   <= '0;
            accepted_reg <= '0;
            vld_reg      <= '0;
        end else if (launch) begin
            base_reg     <= base_addr & ~BRAM_ADDR_WIDTH'(3);
            len_reg      <= len;
            issued_reg   <= '0;
            accepted_reg <= '0;
            vld_reg      <= '0;
        end else begin
            if (issue) begin
                issued_reg <= issued_reg + LEN_WIDTH'(1);
                addr_reg   <= issue_addr;
            end
            if (pop) accepted_reg <= accepted_reg + LEN_WIDTH'(1);
            vld_reg <= {vld_reg[BRAM_RD_LATENCY-2:0], issue};
        end
    end

    bram_stream_reader_sync_fifo #(
        .WIDTH (BRAM_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (fifo_push),
        .wr_data (bus.BRAM_RDDATA),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (unused_fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.m_valid = !fifo_empty;
    assign bus.m_data  = fifo_rd_data;

endmodule
